// File: rtl/guess_button_scanner_if.sv
// Button scanner bus for the Memory Matrix board.
// The master side (board GPIO plus game FSM) drives the raw buttons and the
// acceptance window. The slave side (the scanner) returns the accepted guess
// and its strobes.
interface guess_button_scanner_if;
  logic [7:0] btn_n;        // raw tile buttons, active-low, asynchronous
  logic       enable;       // acceptance window (game FSM in play state)
  logic [7:0] guess;        // one-hot accepted guess, 0 when not valid
  logic       guess_valid;  // level: accepted press still held
  logic       press_pulse;  // strobe on the cycle guess_valid rises
  logic       multi_press;  // strobe when a multi-button press is rejected
  logic       stuck;        // stuck-button flag (optional feature)

  modport master (
    output btn_n, enable,
    input  guess, guess_valid, press_pulse, multi_press, stuck
  );

  modport slave (
    input  btn_n, enable,
    output guess, guess_valid, press_pulse, multi_press, stuck
  );
endinterface

// File: rtl/guess_button_scanner.sv
// guess_button_scanner: synchronises and debounces the 8 tile buttons, then
// turns each physical press into at most one one-hot guess for the game FSM.
// guess_valid stays high until every button is released, so the FSM can wait
// for the release before moving on.
//
// Optional feature macro: GUESS_STUCK_DETECT_EN
//   Defined   : a press held for STUCK_CYCLES is dropped and flagged on 'stuck'
//               until all buttons are released.
//   Undefined : 'stuck' is tied low and a press may be held indefinitely.
module guess_button_scanner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int STUCK_CYCLES    = 150000000
) (
  input  logic                   clk,
  input  logic                   reset,
  guess_button_scanner_if.slave  bus
);

  // Counters only need to hold 0 .. LIMIT-1; the update fires on the last step.
  localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  if (DEBOUNCE_CYCLES < 1 || STUCK_CYCLES < 1) begin : g_param_check
    $error("guess_button_scanner: DEBOUNCE_CYCLES and STUCK_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,    // waiting for a qualified press
    S_HELD,    // single press accepted, guess presented
    S_REJECT   // press rejected (or stuck), waiting for full release
  } state_t;

  // Input conditioning
  logic [7:0]      sync1_q, sync2_q;
  logic [7:0]      db_q, db_d;
  logic [7:0]      db_prev_q;
  logic [DB_W-1:0] db_cnt_q [8];
  logic [DB_W-1:0] db_cnt_d [8];
  logic [7:0]      rise;

  // Press qualification FSM
  state_t     state_q, state_d;
  logic [7:0] held_q, held_d;
  logic       reject_q, reject_d;

  // Registered outputs
  logic [7:0] guess_q;
  logic       guess_valid_q;
  logic       press_pulse_q;
  logic       multi_press_q;

`ifdef GUESS_STUCK_DETECT_EN
  localparam int HOLD_W = (STUCK_CYCLES > 1) ? $clog2(STUCK_CYCLES) : 1;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              stuck_flag_q, stuck_flag_d;
  logic              stuck_q;
`endif

  // Debounce next-state: a bit follows sync only after DEBOUNCE_CYCLES
  // consecutive cycles of disagreement; any agreement restarts the count.
  always_comb begin
    // NOTE: every variable written here gets a default first, otherwise a
    // path that skips the assignment would infer a latch.
    db_d = db_q;
    for (int i = 0; i < 8; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          db_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign rise = db_q & ~db_prev_q;

  // Synchroniser, debounced state and its one-cycle-old copy for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      // NOTE: the debounce counters are eight small per-bit registers, not a
      // RAM, so they are reset like any other flop.
      for (int i = 0; i < 8; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value, e.g. sync2_q gets the old sync1_q.
      sync1_q   <= ~bus.btn_n;
      sync2_q   <= sync1_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
      db_cnt_q  <= db_cnt_d;
    end
  end

  // Press qualification: accept a single-button rising press inside the
  // enable window, reject multi-button presses, release only when all clear.
  always_comb begin
    state_d  = state_q;
    held_d   = held_q;
    reject_d = 1'b0;
`ifdef GUESS_STUCK_DETECT_EN
    hold_cnt_d   = hold_cnt_q;
    stuck_flag_d = stuck_flag_q;
`endif
    unique case (state_q)
      S_IDLE: begin
`ifdef GUESS_STUCK_DETECT_EN
        hold_cnt_d   = '0;
        stuck_flag_d = 1'b0;
`endif
        if (bus.enable && (rise != 8'h00)) begin
          if ($onehot(db_q)) begin
            state_d = S_HELD;
            held_d  = db_q;
          end else begin
            state_d  = S_REJECT;
            reject_d = 1'b1;
          end
        end
      end
      S_HELD: begin
        if (db_q == 8'h00) begin
          state_d = S_IDLE;
          held_d  = '0;
`ifdef GUESS_STUCK_DETECT_EN
        end else if (hold_cnt_q == HOLD_W'(STUCK_CYCLES - 1)) begin
          state_d      = S_REJECT;
          held_d       = '0;
          stuck_flag_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
`endif
        end
      end
      S_REJECT: begin
        if (db_q == 8'h00) begin
          state_d = S_IDLE;
`ifdef GUESS_STUCK_DETECT_EN
          stuck_flag_d = 1'b0;
        end else if (!stuck_flag_q) begin
          if (hold_cnt_q == HOLD_W'(STUCK_CYCLES - 1)) begin
            stuck_flag_d = 1'b1;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
        held_d  = '0;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      held_q   <= '0;
      reject_q <= 1'b0;
`ifdef GUESS_STUCK_DETECT_EN
      hold_cnt_q   <= '0;
      stuck_flag_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      held_q   <= held_d;
      reject_q <= reject_d;
`ifdef GUESS_STUCK_DETECT_EN
      hold_cnt_q   <= hold_cnt_d;
      stuck_flag_q <= stuck_flag_d;
`endif
    end
  end

  // Output register stage: outputs are a clean registered view of the FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      guess_q       <= '0;
      guess_valid_q <= 1'b0;
      press_pulse_q <= 1'b0;
      multi_press_q <= 1'b0;
`ifdef GUESS_STUCK_DETECT_EN
      stuck_q       <= 1'b0;
`endif
    end else begin
      guess_q       <= (state_q == S_HELD) ? held_q : 8'h00;
      guess_valid_q <= (state_q == S_HELD);
      press_pulse_q <= (state_q == S_HELD) && !guess_valid_q;
      multi_press_q <= reject_q;
`ifdef GUESS_STUCK_DETECT_EN
      stuck_q       <= stuck_flag_q;
`endif
    end
  end

  assign bus.guess       = guess_q;
  assign bus.guess_valid = guess_valid_q;
  assign bus.press_pulse = press_pulse_q;
  assign bus.multi_press = multi_press_q;
`ifdef GUESS_STUCK_DETECT_EN
  assign bus.stuck       = stuck_q;
`else
  assign bus.stuck       = 1'b0;
`endif

endmodule

// File: tb/tb_guess_button_scanner.sv
// Testbench for guess_button_scanner: directed scenarios with hand-computed
// expectations plus randomized button traffic, all checked every cycle
// against a behavioural model of the press-acceptance rules.
module tb_guess_button_scanner;

  localparam int N     = 4;   // debounce cycles used by the bench
  localparam int STUCK = 64;  // stuck limit used by the bench
`ifdef GUESS_STUCK_DETECT_EN
  localparam bit STUCK_EN = 1'b1;
`else
  localparam bit STUCK_EN = 1'b0;
`endif

  logic clk;
  logic reset;
  guess_button_scanner_if bus ();

  guess_button_scanner #(
    .DEBOUNCE_CYCLES (N),
    .STUCK_CYCLES    (STUCK)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [7:0] hist [$];     // raw pressed samples, oldest first, N+2 deep
  logic [7:0] db_now, db_old;
  bit         busy, showing, stuck_m, rej_evt;
  logic [7:0] shown;
  int         hold;
  logic [7:0] exp_guess;
  bit         exp_valid, exp_pulse, exp_multi, exp_stuck;

  // Directed-scenario bookkeeping
  int edge_no, pulse_edge, fall_edge, pulse_cnt, multi_cnt, valid_seen, stuck_seen;
  bit prev_valid;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k < N + 2; k++) hist.push_back(8'h00);
    db_now = '0; db_old = '0;
    busy = 0; showing = 0; stuck_m = 0; rej_evt = 0;
    shown = '0; hold = 0;
    exp_guess = '0; exp_valid = 0; exp_pulse = 0; exp_multi = 0; exp_stuck = 0;
  endtask

  // One clock edge of the rules: outputs show the decision made one edge
  // earlier; decisions see the debounced buttons as they were before this edge.
  task automatic model_edge();
    logic [7:0] db_new;
    bit         flip;
    exp_pulse = showing && !exp_valid;
    exp_guess = showing ? shown : 8'h00;
    exp_valid = showing;
    exp_multi = rej_evt;
    exp_stuck = stuck_m;

    rej_evt = 0;
    if (!busy) begin
      hold = 0;
      if (bus.enable && ((db_now & ~db_old) != 8'h00)) begin
        busy = 1;
        if ($countones(db_now) == 1) begin
          showing = 1;
          shown   = db_now;
        end else begin
          rej_evt = 1;
        end
      end
    end else if (db_now == 8'h00) begin
      busy = 0; showing = 0; stuck_m = 0;
    end else if (STUCK_EN && !stuck_m) begin
      hold++;
      if (hold == STUCK) begin
        stuck_m = 1;
        showing = 0;
      end
    end

    // A bit changes once the raw samples taken 2..N+1 edges ago all disagree.
    hist.push_back(~bus.btn_n);
    void'(hist.pop_front());
    db_new = db_now;
    for (int i = 0; i < 8; i++) begin
      flip = 1;
      for (int k = 0; k < N; k++) if (hist[k][i] == db_now[i]) flip = 0;
      if (flip) db_new[i] = ~db_now[i];
    end
    db_old = db_now;
    db_now = db_new;
  endtask

  task automatic compare();
    checks++;
    if (bus.guess !== exp_guess || bus.guess_valid !== exp_valid ||
        bus.press_pulse !== exp_pulse || bus.multi_press !== exp_multi ||
        bus.stuck !== exp_stuck) begin
      errors++;
      $display("FAIL model t=%0t: got guess=%h valid=%b pulse=%b multi=%b stuck=%b, expected guess=%h valid=%b pulse=%b multi=%b stuck=%b",
               $time, bus.guess, bus.guess_valid, bus.press_pulse, bus.multi_press, bus.stuck,
               exp_guess, exp_valid, exp_pulse, exp_multi, exp_stuck);
    end
  endtask

  task automatic mark();
    edge_no = 0; pulse_edge = -1; fall_edge = -1;
    pulse_cnt = 0; multi_cnt = 0; valid_seen = 0; stuck_seen = 0;
  endtask

  // Drive inputs at the falling edge, let one rising edge happen, then
  // advance the model and compare at the next falling edge.
  task automatic tick(input logic [7:0] b, input logic en);
    bus.btn_n  = b;
    bus.enable = en;
    @(posedge clk);
    @(negedge clk);
    if (reset) model_reset();
    else       model_edge();
    compare();
    if (bus.press_pulse) begin
      pulse_cnt++;
      if (pulse_edge < 0) pulse_edge = edge_no;
    end
    if (bus.multi_press) multi_cnt++;
    if (bus.guess_valid) valid_seen++;
    if (bus.stuck) stuck_seen++;
    if (!bus.guess_valid && prev_valid && fall_edge < 0) fall_edge = edge_no;
    prev_valid = bus.guess_valid;
    edge_no++;
  endtask

  task automatic run(input logic [7:0] b, input logic en, input int n);
    for (int k = 0; k < n; k++) tick(b, en);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " guess"},       32'(bus.guess),       32'h0);
    check({tag, " guess_valid"}, 32'(bus.guess_valid), 32'h0);
    check({tag, " press_pulse"}, 32'(bus.press_pulse), 32'h0);
    check({tag, " multi_press"}, 32'(bus.multi_press), 32'h0);
    check({tag, " stuck"},       32'(bus.stuck),       32'h0);
  endtask

  // Asynchronous reset pulse applied between clock edges
  task automatic pulse_reset(input string tag);
    reset = 1'b1;
    #1;
    check_all_zero(tag);
    model_reset();
    prev_valid = 0;
    tick(bus.btn_n, bus.enable);
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    bus.btn_n = 8'hFF;
    bus.enable = 1'b0;
    prev_valid = 0;
    model_reset();
    mark();

    // Reset state
    run(8'hFF, 1'b0, 3);
    check_all_zero("reset");
    reset = 1'b0;
    run(8'hFF, 1'b1, 8);

    // Single press: pulse exactly N+3 edges after the raw edge
    mark();
    run(8'hFB, 1'b1, 20);
    check("single pulse_edge", 32'(pulse_edge), 32'd7);
    check("single pulse_cnt",  32'(pulse_cnt),  32'd1);
    check("single guess",      32'(bus.guess),  32'h04);
    check("single valid",      32'(bus.guess_valid), 32'h1);
    mark();
    run(8'hFF, 1'b1, 12);
    check("release fall_edge", 32'(fall_edge), 32'd7);
    check("release guess",     32'(bus.guess), 32'h0);

    // Bounce shorter than the debounce window never registers
    mark();
    run(8'hFE, 1'b1, 3);
    run(8'hFF, 1'b1, 2);
    run(8'hFE, 1'b1, 3);
    run(8'hFF, 1'b1, 10);
    check("bounce valid_seen", 32'(valid_seen), 32'd0);
    mark();
    run(8'hFE, 1'b1, 10);
    check("bounce guess",     32'(bus.guess), 32'h01);
    check("bounce pulse_cnt", 32'(pulse_cnt), 32'd1);
    run(8'hFF, 1'b1, 10);

    // Two buttons in the same cycle are rejected
    mark();
    run(8'hF6, 1'b1, 12);
    check("multi multi_cnt",  32'(multi_cnt),  32'd1);
    check("multi valid_seen", 32'(valid_seen), 32'd0);
    run(8'hFF, 1'b1, 10);
    mark();
    run(8'hFE, 1'b1, 12);
    check("after multi guess", 32'(bus.guess), 32'h01);
    check("after multi pulse", 32'(pulse_cnt), 32'd1);
    run(8'hFF, 1'b1, 10);

    // Enable gating: a button already down when enable rises is ignored
    mark();
    run(8'hF7, 1'b0, 10);
    run(8'hF7, 1'b1, 10);
    check("gated pulse_cnt",  32'(pulse_cnt),  32'd0);
    check("gated valid_seen", 32'(valid_seen), 32'd0);
    run(8'hFF, 1'b1, 10);
    run(8'hF7, 1'b1, 10);
    check("regated guess", 32'(bus.guess), 32'h08);
    run(8'hF7, 1'b0, 5);
    check("enable drop valid", 32'(bus.guess_valid), 32'h1);
    mark();
    run(8'hFF, 1'b0, 12);
    check("enable drop fall_edge", 32'(fall_edge), 32'd7);

    // Reset mid-hold: the still-held button is accepted again after reset
    run(8'hEF, 1'b1, 12);
    check("pre-reset guess", 32'(bus.guess), 32'h10);
    pulse_reset("mid-hold reset");
    mark();
    run(8'hEF, 1'b1, 12);
    check("post-reset guess", 32'(bus.guess), 32'h10);
    check("post-reset pulse", 32'(pulse_cnt), 32'd1);
    run(8'hFF, 1'b1, 10);

    // Long hold
    mark();
    run(8'hDF, 1'b1, 100);
    check("long hold pulse_cnt", 32'(pulse_cnt), 32'd1);
    check("long hold multi_cnt", 32'(multi_cnt), 32'd0);
`ifdef GUESS_STUCK_DETECT_EN
    check("stuck flag",        32'(bus.stuck),       32'h1);
    check("stuck valid",       32'(bus.guess_valid), 32'h0);
    check("stuck fall_edge",   32'(fall_edge),       32'd71);
`else
    check("hold valid",        32'(bus.guess_valid), 32'h1);
    check("hold guess",        32'(bus.guess),       32'h20);
    check("hold stuck_seen",   32'(stuck_seen),      32'd0);
`endif
    run(8'hFF, 1'b1, 12);
    check("after hold stuck", 32'(bus.stuck),       32'h0);
    check("after hold valid", 32'(bus.guess_valid), 32'h0);

    // Randomized traffic against the model
    for (int seg = 0; seg < 400; seg++) begin
      logic [7:0] pat;
      int         r;
      r = $urandom_range(0, 9);
      if (r <= 3)      pat = 8'hFF;
      else if (r <= 7) pat = ~(8'h01 << $urandom_range(0, 7));
      else if (r == 8) pat = ~((8'h01 << $urandom_range(0, 7)) | (8'h01 << $urandom_range(0, 7)));
      else             pat = 8'($urandom);
      if ($urandom_range(0, 59) == 0) pulse_reset("random reset");
      run(pat, ($urandom_range(0, 7) != 0), $urandom_range(1, 14));
    end
    run(8'hFF, 1'b1, 12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
